// File: rtl/rtc_disciplined_if.sv
// Bus bundle for rtc_disciplined.
//   master : timebase user (drives SetTime/LatchTime/Trim/Pps/alarms/Capture,
//            receives Time, AlarmHit, CaptureTime, CaptureValid)
//   slave  : the RTC itself
// Time packing (72 bits, all binary):
//   {century9, year7, month4, day5, hour5, min6, sec6, ms10, us10, ns10}
interface rtc_disciplined_if #(
  parameter int unsigned FRAC_W  = 16,
  parameter int unsigned N_ALARM = 2
);
  logic [71:0]           Time;
  logic [71:0]           SetTime;
  logic                  LatchTime;
  logic [FRAC_W:0]       Trim;
  logic                  PpsEnable;
  logic                  Pps;
  logic [72*N_ALARM-1:0] AlarmTime;
  logic [N_ALARM-1:0]    AlarmEnable;
  logic [N_ALARM-1:0]    AlarmHit;
  logic                  Capture;
  logic [71:0]           CaptureTime;
  logic                  CaptureValid;

  modport master (
    input  Time, AlarmHit, CaptureTime, CaptureValid,
    output SetTime, LatchTime, Trim, PpsEnable, Pps, AlarmTime, AlarmEnable, Capture
  );

  modport slave (
    output Time, AlarmHit, CaptureTime, CaptureValid,
    input  SetTime, LatchTime, Trim, PpsEnable, Pps, AlarmTime, AlarmEnable, Capture
  );
endinterface

// File: rtl/rtc_disciplined.sv
// Calendar real-time clock, century down to nanoseconds, with fixed-point
// per-cycle step, runtime rate trim, PPS discipline, second-resolution alarms
// and timestamp capture.
// Ports:
//   Clk     : clock
//   nReset  : asynchronous active-low reset
//   bus     : rtc_disciplined_if.slave (Time, SetTime, LatchTime, Trim, PpsEnable,
//             Pps, AlarmTime, AlarmEnable, AlarmHit, Capture, CaptureTime,
//             CaptureValid)
module rtc_disciplined #(
  parameter int unsigned NS_INC   = 20,
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned FRAC_INC = 0,
  parameter int unsigned N_ALARM  = 2
) (
  input logic              Clk,
  input logic              nReset,
  rtc_disciplined_if.slave bus
);

  localparam logic [71:0]       ResetTime = {9'd20, 7'd0, 4'd1, 5'd1, 47'd0};
  localparam logic [10:0]       NsInc     = 11'(NS_INC);
  localparam logic [FRAC_W-1:0] FracInc   = FRAC_W'(FRAC_INC);

  logic [71:0]        time_q, time_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic               pps_q;
  logic [N_ALARM-1:0] alarm_hit_q, alarm_hit_d;
  logic [71:0]        capture_time_q;
  logic               capture_valid_q;

  // Current fields
  logic [8:0] century;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day, hour;
  logic [5:0] minute, sec;
  logic [9:0] ms, us, ns;

  assign {century, year, month, day, hour, minute, sec, ms, us, ns} = time_q;

  // Days in the given month; invalid months count as 31.
  function automatic logic [4:0] month_len(logic [3:0] m, logic [6:0] y, logic [8:0] c);
    logic leap;
    leap = ((y[1:0] == 2'd0) && (y != 7'd0)) || ((y == 7'd0) && (c[1:0] == 2'd0));
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return leap ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Step = FracInc + Trim, clamped to the unsigned fraction range.
  logic signed [FRAC_W+1:0] step_raw;
  logic [FRAC_W-1:0]        step;
  logic [FRAC_W:0]          frac_sum;

  assign step_raw = $signed({2'b00, FracInc}) + $signed({bus.Trim[FRAC_W], bus.Trim});

  always_comb begin
    step = step_raw[FRAC_W-1:0];
    if (step_raw[FRAC_W+1]) begin
      step = '0;
    end else if (step_raw[FRAC_W]) begin
      step = '1;
    end
  end

  assign frac_sum = {1'b0, frac_q} + {1'b0, step};

  // Sub-second step. Fields loaded out of range still make progress because
  // the wrap tests use >= rather than ==.
  logic [10:0] ns_sum;
  logic        ns_wrap, us_wrap, ms_wrap;
  logic [9:0]  ns_step, us_step, ms_step;

  assign ns_sum = {1'b0, ns} + NsInc + {10'd0, frac_sum[FRAC_W]};

  always_comb begin
    ns_wrap = (ns_sum >= 11'd1000);
    ns_step = ns_wrap ? 10'(ns_sum - 11'd1000) : ns_sum[9:0];
    us_wrap = 1'b0;
    us_step = us;
    ms_wrap = 1'b0;
    ms_step = ms;
    if (ns_wrap) begin
      if (us >= 10'd999) begin
        us_step = '0;
        us_wrap = 1'b1;
      end else begin
        us_step = us + 10'd1;
      end
    end
    if (us_wrap) begin
      if (ms >= 10'd999) begin
        ms_step = '0;
        ms_wrap = 1'b1;
      end else begin
        ms_step = ms + 10'd1;
      end
    end
  end

  // PPS discipline: snap to the nearest whole second on a qualified rising edge.
  logic pps_edge;
  logic round_up;
  logic sec_in;

  assign pps_edge = bus.PpsEnable & bus.Pps & ~pps_q;
  assign round_up = (ms >= 10'd500);
  assign sec_in   = pps_edge ? round_up : ms_wrap;

  // Second-and-up carry chain
  logic [8:0]  century_n;
  logic [6:0]  year_n;
  logic [3:0]  month_n;
  logic [4:0]  day_n, hour_n;
  logic [5:0]  minute_n, sec_n;
  logic        c_min, c_hour, c_day, c_month, c_year, c_century;
  logic [71:0] time_next;

  always_comb begin
    century_n = century;
    year_n    = year;
    month_n   = month;
    day_n     = day;
    hour_n    = hour;
    minute_n  = minute;
    sec_n     = sec;
    c_min     = 1'b0;
    c_hour    = 1'b0;
    c_day     = 1'b0;
    c_month   = 1'b0;
    c_year    = 1'b0;
    c_century = 1'b0;
    if (sec_in) begin
      if (sec >= 6'd59) begin
        sec_n = '0;
        c_min = 1'b1;
      end else begin
        sec_n = sec + 6'd1;
      end
    end
    if (c_min) begin
      if (minute >= 6'd59) begin
        minute_n = '0;
        c_hour   = 1'b1;
      end else begin
        minute_n = minute + 6'd1;
      end
    end
    if (c_hour) begin
      if (hour >= 5'd23) begin
        hour_n = '0;
        c_day  = 1'b1;
      end else begin
        hour_n = hour + 5'd1;
      end
    end
    if (c_day) begin
      if (day >= month_len(month, year, century)) begin
        day_n   = 5'd1;
        c_month = 1'b1;
      end else begin
        day_n = day + 5'd1;
      end
    end
    if (c_month) begin
      // Months 13-15 roll over like December.
      if (month >= 4'd12) begin
        month_n = 4'd1;
        c_year  = 1'b1;
      end else begin
        month_n = month + 4'd1;
      end
    end
    if (c_year) begin
      if (year >= 7'd99) begin
        year_n    = '0;
        c_century = 1'b1;
      end else begin
        year_n = year + 7'd1;
      end
    end
    if (c_century) begin
      century_n = century + 9'd1;
    end
  end

  always_comb begin
    time_next = {century_n, year_n, month_n, day_n, hour_n, minute_n, sec_n,
                 pps_edge ? 10'd0 : ms_step,
                 pps_edge ? 10'd0 : us_step,
                 pps_edge ? 10'd0 : ns_step};
    if (bus.LatchTime) begin
      time_d = bus.SetTime;
      frac_d = '0;
    end else begin
      time_d = time_next;
      frac_d = pps_edge ? '0 : frac_sum[FRAC_W-1:0];
    end
  end

  // Alarms fire only when the time enters a new second by counting or PPS round-up.
  always_comb begin
    alarm_hit_d = '0;
    for (int i = 0; i < int'(N_ALARM); i++) begin
      alarm_hit_d[i] = ~bus.LatchTime & sec_in & bus.AlarmEnable[i] &
                       (time_next[71:30] == bus.AlarmTime[72*i+30 +: 42]);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      time_q          <= ResetTime;
      frac_q          <= '0;
      pps_q           <= 1'b0;
      alarm_hit_q     <= '0;
      capture_time_q  <= '0;
      capture_valid_q <= 1'b0;
    end else begin
      time_q          <= time_d;
      frac_q          <= frac_d;
      pps_q           <= bus.Pps;
      alarm_hit_q     <= alarm_hit_d;
      capture_valid_q <= bus.Capture;
      if (bus.Capture) begin
        capture_time_q <= time_q;
      end
    end
  end

  assign bus.Time         = time_q;
  assign bus.AlarmHit     = alarm_hit_q;
  assign bus.CaptureTime  = capture_time_q;
  assign bus.CaptureValid = capture_valid_q;

endmodule

// File: tb/tb_rtc_disciplined.sv
module tb_rtc_disciplined;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int   checks = 0;
  int   fails = 0;

  always #5 Clk = ~Clk;

  rtc_disciplined_if #(.FRAC_W(16), .N_ALARM(2)) bus ();
  rtc_disciplined_if #(.FRAC_W(4), .N_ALARM(1)) sbus ();

  rtc_disciplined #(.NS_INC(20), .FRAC_W(16), .FRAC_INC(0), .N_ALARM(2)) dut (
    .Clk(Clk), .nReset(nReset), .bus(bus)
  );

  rtc_disciplined #(.NS_INC(6), .FRAC_W(4), .FRAC_INC(8), .N_ALARM(1)) dut_s (
    .Clk(Clk), .nReset(nReset), .bus(sbus)
  );

  function automatic logic [71:0] mk(int c, int y, int mo, int d, int h, int mi, int s,
                                     int ms, int us, int ns);
    return {9'(c), 7'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s), 10'(ms), 10'(us), 10'(ns)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [71:0] t);
    bus.SetTime   = t;
    bus.LatchTime = 1'b1;
    tick();
    bus.LatchTime = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] exp;
    exp = mk(20, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    nReset = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL reset_time: got %h want %h", bus.Time, exp);
    end
    checks++;
    if (bus.AlarmHit !== 2'b00) begin
      fails++; $display("FAIL reset_alarm: got %b want 00", bus.AlarmHit);
    end
    checks++;
    if (bus.CaptureValid !== 1'b0) begin
      fails++; $display("FAIL reset_capvalid: got %b want 0", bus.CaptureValid);
    end
    checks++;
    if (bus.CaptureTime !== 72'd0) begin
      fails++; $display("FAIL reset_captime: got %h want 0", bus.CaptureTime);
    end
    checks++;
    if (sbus.Time !== exp) begin
      fails++; $display("FAIL reset_time_small: got %h want %h", sbus.Time, exp);
    end
    nReset = 1'b1;
    #1;
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL reset_release: got %h want %h", bus.Time, exp);
    end
  endtask

  task automatic test_frac_step();
    int exp_ns [9] = '{6, 13, 19, 26, 32, 38, 44, 51, 58};
    sbus.SetTime   = mk(20, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    sbus.LatchTime = 1'b1;
    tick();
    sbus.LatchTime = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) sbus.Trim = 5'b11000;  // -8: step 0
      if (i == 6) sbus.Trim = 5'b01111;  // +15: clamps to 15
      tick();
      checks++;
      if (sbus.Time[9:0] !== 10'(exp_ns[i])) begin
        fails++;
        $display("FAIL frac_step[%0d]: got ns=%0d want ns=%0d", i, sbus.Time[9:0], exp_ns[i]);
      end
    end
    sbus.Trim = '0;
  endtask

  task automatic test_leap();
    logic [71:0] vin [4];
    logic [71:0] vexp [4];
    vin[0] = mk(21, 0, 2, 28, 23, 59, 59, 999, 999, 980);
    vexp[0] = mk(21, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    vin[1] = mk(20, 0, 2, 28, 23, 59, 59, 999, 999, 980);
    vexp[1] = mk(20, 0, 2, 29, 0, 0, 0, 0, 0, 0);
    vin[2] = mk(20, 0, 4, 30, 23, 59, 59, 999, 999, 980);
    vexp[2] = mk(20, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    vin[3] = mk(20, 99, 12, 31, 23, 59, 59, 999, 999, 990);
    vexp[3] = mk(21, 0, 1, 1, 0, 0, 0, 0, 0, 10);
    for (int i = 0; i < 4; i++) begin
      load(vin[i]);
      tick();
      checks++;
      if (bus.Time !== vexp[i]) begin
        fails++; $display("FAIL leap[%0d]: got %h want %h", i, bus.Time, vexp[i]);
      end
    end
  endtask

  task automatic test_pps();
    logic [71:0] exp;
    load(mk(20, 0, 1, 1, 12, 0, 0, 499, 999, 0));
    bus.PpsEnable = 1'b1;
    bus.Pps       = 1'b1;
    tick();
    exp = mk(20, 0, 1, 1, 12, 0, 0, 0, 0, 0);
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL pps_round_down: got %h want %h", bus.Time, exp);
    end
    bus.Pps = 1'b0;
    tick();
    load(mk(20, 0, 1, 1, 12, 0, 0, 500, 0, 0));
    bus.Pps = 1'b1;
    tick();
    exp = mk(20, 0, 1, 1, 12, 0, 1, 0, 0, 0);
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL pps_round_up: got %h want %h", bus.Time, exp);
    end
    // Enabling while Pps already high must not count as an edge.
    bus.Pps       = 1'b1;
    bus.PpsEnable = 1'b0;
    load(mk(20, 0, 1, 1, 12, 0, 5, 700, 0, 0));
    bus.PpsEnable = 1'b1;
    tick();
    exp = mk(20, 0, 1, 1, 12, 0, 5, 700, 0, 20);
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL pps_enable_high: got %h want %h", bus.Time, exp);
    end
    bus.Pps = 1'b0;
    tick();
    exp = mk(20, 0, 1, 1, 13, 0, 0, 700, 0, 0);
    bus.SetTime   = exp;
    bus.LatchTime = 1'b1;
    bus.Pps       = 1'b1;
    tick();
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL pps_vs_latch: got %h want %h", bus.Time, exp);
    end
    bus.LatchTime = 1'b0;
    bus.Pps       = 1'b0;
    bus.PpsEnable = 1'b0;
    tick();
  endtask

  task automatic test_alarm();
    logic [71:0] a;
    a = mk(20, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    bus.AlarmTime   = {a, a};
    bus.AlarmEnable = 2'b01;
    load(a);
    checks++;
    if (bus.AlarmHit !== 2'b00) begin
      fails++; $display("FAIL alarm_latch: got %b want 00", bus.AlarmHit);
    end
    load(mk(20, 0, 1, 1, 0, 0, 0, 999, 999, 980));
    checks++;
    if (bus.AlarmHit !== 2'b00) begin
      fails++; $display("FAIL alarm_early: got %b want 00", bus.AlarmHit);
    end
    tick();
    checks++;
    if (bus.AlarmHit !== 2'b01 || bus.Time !== a) begin
      fails++; $display("FAIL alarm_step: got %b/%h want 01/%h", bus.AlarmHit, bus.Time, a);
    end
    tick();
    checks++;
    if (bus.AlarmHit !== 2'b00) begin
      fails++; $display("FAIL alarm_pulse: got %b want 00", bus.AlarmHit);
    end
    load(mk(20, 0, 1, 1, 0, 0, 0, 600, 0, 0));
    bus.PpsEnable = 1'b1;
    bus.Pps       = 1'b1;
    tick();
    checks++;
    if (bus.AlarmHit !== 2'b01 || bus.Time !== a) begin
      fails++; $display("FAIL alarm_pps_up: got %b/%h want 01/%h", bus.AlarmHit, bus.Time, a);
    end
    bus.Pps = 1'b0;
    tick();
    load(mk(20, 0, 1, 1, 0, 0, 1, 200, 0, 0));
    bus.Pps = 1'b1;
    tick();
    checks++;
    if (bus.AlarmHit !== 2'b00 || bus.Time !== a) begin
      fails++; $display("FAIL alarm_pps_down: got %b/%h want 00/%h", bus.AlarmHit, bus.Time, a);
    end
    bus.Pps       = 1'b0;
    bus.PpsEnable = 1'b0;
    bus.AlarmEnable = 2'b11;
    load(mk(20, 0, 1, 1, 0, 0, 0, 999, 999, 980));
    tick();
    checks++;
    if (bus.AlarmHit !== 2'b11) begin
      fails++; $display("FAIL alarm_both: got %b want 11", bus.AlarmHit);
    end
    bus.AlarmEnable = 2'b00;
    tick();
  endtask

  task automatic test_capture();
    logic [71:0] t0, t1;
    t0 = mk(20, 0, 1, 1, 1, 2, 3, 4, 5, 100);
    t1 = mk(20, 0, 1, 1, 1, 2, 3, 4, 5, 120);
    load(t0);
    bus.Capture = 1'b1;
    tick();
    checks++;
    if (bus.CaptureValid !== 1'b1 || bus.CaptureTime !== t0) begin
      fails++;
      $display("FAIL capture_single: got %b/%h want 1/%h", bus.CaptureValid, bus.CaptureTime, t0);
    end
    bus.Capture = 1'b0;
    tick();
    checks++;
    if (bus.CaptureValid !== 1'b0) begin
      fails++; $display("FAIL capture_pulse: got %b want 0", bus.CaptureValid);
    end
    load(t0);
    bus.Capture = 1'b1;
    tick();
    checks++;
    if (bus.CaptureValid !== 1'b1 || bus.CaptureTime !== t0) begin
      fails++;
      $display("FAIL capture_b2b_0: got %b/%h want 1/%h", bus.CaptureValid, bus.CaptureTime, t0);
    end
    tick();
    checks++;
    if (bus.CaptureValid !== 1'b1 || bus.CaptureTime !== t1) begin
      fails++;
      $display("FAIL capture_b2b_1: got %b/%h want 1/%h", bus.CaptureValid, bus.CaptureTime, t1);
    end
    bus.Capture = 1'b0;
    tick();
    checks++;
    if (bus.CaptureValid !== 1'b0) begin
      fails++; $display("FAIL capture_end: got %b want 0", bus.CaptureValid);
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] exp;
    exp = mk(20, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    load(mk(20, 5, 6, 7, 8, 9, 10, 11, 12, 13));
    bus.Capture = 1'b1;
    tick();
    bus.Capture = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    checks++;
    if (bus.Time !== exp) begin
      fails++; $display("FAIL reset_mid_time: got %h want %h", bus.Time, exp);
    end
    checks++;
    if (bus.CaptureValid !== 1'b0 || bus.CaptureTime !== 72'd0) begin
      fails++;
      $display("FAIL reset_mid_cap: got %b/%h want 0/0", bus.CaptureValid, bus.CaptureTime);
    end
    tick();
    nReset = 1'b1;
    tick();
  endtask

  initial begin
    bus.SetTime     = '0;
    bus.LatchTime   = 1'b0;
    bus.Trim        = '0;
    bus.PpsEnable   = 1'b0;
    bus.Pps         = 1'b0;
    bus.AlarmTime   = '0;
    bus.AlarmEnable = '0;
    bus.Capture     = 1'b0;
    sbus.SetTime     = '0;
    sbus.LatchTime   = 1'b0;
    sbus.Trim        = '0;
    sbus.PpsEnable   = 1'b0;
    sbus.Pps         = 1'b0;
    sbus.AlarmTime   = '0;
    sbus.AlarmEnable = '0;
    sbus.Capture     = 1'b0;

    test_reset();
    test_frac_step();
    test_leap();
    test_pps();
    test_alarm();
    test_capture();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
